uart_rx_word_packer: RTL and testbench

Receive-side stage placed directly downstream of the UART byte receiver. It takes each received byte strobe and buffers it in a byte FIFO. It packs consecutive good bytes into 32-bit words, first byte in the most-significant position, and hands the words to the CPU loader/MMIO side over a valid/ready handshake. Bytes with a framing error are dropped and counted; bytes arriving with the FIFO full are dropped and flagged.

---
 rtl/uart_rx_word_packer_if.sv | 33 +++
 rtl/uart_rx_word_packer.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_word_packer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_word_packer_if.sv
// ---------------------------------------------------------------------------
// uart_rx_word_packer_if
//
// Purpose:
//   Valid/ready word stream between the UART word packer and whatever consumes
//   packed 32-bit words (CPU loader or MMIO read port).
//
// Signals:
//   word_out   - packed word, first received byte in [31:24]
//   word_valid - word_out holds a complete word
//   word_ready - consumer accepts the word on this edge
//
// Modports:
//   master - the packer, which produces words
//   slave  - the consumer, which accepts words
// ---------------------------------------------------------------------------
interface uart_rx_word_packer_if;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;

    modport master (
        output word_out,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/uart_rx_word_packer.sv
// ---------------------------------------------------------------------------
// uart_rx_word_packer
//
// Purpose:
//   Sits directly behind the UART byte receiver. Good bytes are buffered in a
//   byte FIFO. They are then packed four at a time into 32-bit words, with the
//   first byte in the most-significant lane. Each word is offered on a
//   valid/ready stream. Bytes with a framing error are dropped and counted.
//   Good bytes that arrive while the FIFO is full are dropped, and a sticky
//   overflow flag is raised.
//
// Parameters:
//   DEPTH        - byte FIFO depth (power of two, >= 2)
//
// Ports:
//   clk          - clock
//   rstn         - synchronous, active-low reset
//   i_rx_data    - received byte, meaningful only while i_rx_valid is high
//   i_rx_valid   - one-cycle byte strobe from the receiver
//   i_rx_ferr    - framing error for the byte strobed this cycle
//   i_flush      - discard all buffered and partially packed bytes
//   i_clear_err  - clear o_ferr_count and o_overflow
//   word_bus     - packed word stream (master side)
//   o_fifo_level - number of bytes currently held in the FIFO
//   o_overflow   - sticky flag: a good byte was lost to a full FIFO
//   o_ferr_count - saturating count of bytes dropped for framing errors
// ---------------------------------------------------------------------------
module uart_rx_word_packer #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    input  logic                   i_rx_ferr,
    input  logic                   i_flush,
    input  logic                   i_clear_err,
    uart_rx_word_packer_if.master  word_bus,
    output logic [$clog2(DEPTH):0] o_fifo_level,
    output logic                   o_overflow,
    output logic [7:0]             o_ferr_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic {
        S_COLLECT,
        S_HOLD
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_count;

    // Packer state
    state_t        r_state;
    logic [1:0]    r_idx;
    logic [7:0]    r_lane0;
    logic [7:0]    r_lane1;
    logic [7:0]    r_lane2;
    logic [31:0]   r_word_out;
    logic          r_word_valid;

    // Error reporting
    logic          r_overflow;
    logic [7:0]    r_ferr_count;

    // Per-edge events
    logic          w_pop;
    logic          w_room;
    logic          w_good;
    logic          w_push;
    logic          w_drop;
    logic          w_ferr_evt;
    logic [7:0]    w_pop_data;

    // Pops are decided from the pre-edge level. A byte written on this edge
    // therefore cannot also be popped on it, so there is no bypass path.
    // The room test counts a same-edge pop as freeing a slot. This lets a
    // full FIFO keep streaming while the packer drains it.
    assign w_pop      = (r_state == S_COLLECT) && (r_count != '0) && !i_flush;
    assign w_room     = (r_count < FULL_LEVEL) || w_pop;
    assign w_good     = i_rx_valid && !i_rx_ferr && !i_flush;
    assign w_push     = w_good && w_room;
    assign w_drop     = w_good && !w_room;
    assign w_ferr_evt = i_rx_valid && i_rx_ferr;
    assign w_pop_data = r_mem[r_rptr];

    // Byte storage. This block has no reset because the pointers alone
    // decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (rstn && w_push) begin
            r_mem[r_wptr] <= i_rx_data;
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally. The level is
    // kept as its own register so that it can be output directly and can
    // represent both 0 and DEPTH. A flush returns everything to the empty
    // state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Packer FSM. In COLLECT it takes one byte per edge into lane r_idx.
    // The fourth byte goes straight into the registered word together with
    // the three stored lanes. The FSM then waits in HOLD until the consumer
    // takes the word. A flush abandons any partial word and the offered
    // word. word_out itself keeps its value, so the bus does not glitch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_COLLECT;
            r_idx        <= '0;
            r_lane0      <= '0;
            r_lane1      <= '0;
            r_lane2      <= '0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
        end else if (i_flush) begin
            r_state      <= S_COLLECT;
            r_idx        <= '0;
            r_word_valid <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_pop) begin
                        case (r_idx)
                            2'd0: r_lane0 <= w_pop_data;
                            2'd1: r_lane1 <= w_pop_data;
                            2'd2: r_lane2 <= w_pop_data;
                            2'd3: begin
                                r_word_out   <= {r_lane0, r_lane1, r_lane2, w_pop_data};
                                r_word_valid <= 1'b1;
                                r_state      <= S_HOLD;
                            end
                            default: r_lane0 <= r_lane0;
                        endcase
                        // The increment wraps 3 -> 0 as the word completes.
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_word_valid && word_bus.word_ready) begin
                        r_word_valid <= 1'b0;
                        r_state      <= S_COLLECT;
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

    // Error counters. Flush does not affect them. A counted event on the same
    // edge as clear_err takes priority, so that a single fresh error is never
    // lost to a clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ferr_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_ferr_evt) begin
                if (i_clear_err) begin
                    r_ferr_count <= 8'd1;
                end else if (r_ferr_count != 8'hFF) begin
                    r_ferr_count <= r_ferr_count + 1'b1;
                end
            end else if (i_clear_err) begin
                r_ferr_count <= '0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clear_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign word_bus.word_out   = r_word_out;
    assign word_bus.word_valid = r_word_valid;
    assign o_fifo_level        = r_count;
    assign o_overflow          = r_overflow;
    assign o_ferr_count        = r_ferr_count;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_word_packer
//
// Purpose:
//   Self-checking bench for uart_rx_word_packer (DEPTH = 16). It drives
//   directed vectors and corner-case sequences, followed by a randomized run.
//   Every cycle it compares all outputs against a queue-based reference
//   model.
// ---------------------------------------------------------------------------
module tb_uart_rx_word_packer;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxFerr;
    logic        flush;
    logic        clearErr;
    logic [4:0]  fifoLevel;
    logic        overflow;
    logic [7:0]  ferrCount;

    uart_rx_word_packer_if wordBus();

    uart_rx_word_packer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_rx_data    (rxData),
        .i_rx_valid   (rxValid),
        .i_rx_ferr    (rxFerr),
        .i_flush      (flush),
        .i_clear_err  (clearErr),
        .word_bus     (wordBus),
        .o_fifo_level (fifoLevel),
        .o_overflow   (overflow),
        .o_ferr_count (ferrCount)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state. The byte buffer and the partially collected
    // word are both plain queues.
    logic [7:0]  mFifo[$];
    logic [7:0]  mColl[$];
    logic [31:0] mWordOut;
    logic        mWordValid;
    logic        mOverflow;
    logic [7:0]  mFerrCount;

    // Words the DUT handed over, and the words a sequence expects
    logic [31:0] accepted[$];
    logic [31:0] expWords[$];

    // Cycle bookkeeping used by the latency test
    int cycle;
    int wvHighCount;
    int firstWvCycle;

    typedef struct {
        logic        rv;
        logic [7:0]  d;
        logic        fe;
        logic        fl;
        logic        ce;
        logic        rdy;
        logic        expWv;
        logic [31:0] expWo;
        int          expLvl;
        logic        expOv;
        int          expFc;
    } vec_t;

    vec_t vecs[14];

    // Single comparison point: it bumps the counters and reports a mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advances the model by one clock edge using the inputs seen at that edge
    task automatic modelStep();
        bit pop, room, pushEv, dropEv, ferrEv;
        if (!rstn) begin
            mFifo.delete();
            mColl.delete();
            mWordOut   = '0;
            mWordValid = 1'b0;
            mOverflow  = 1'b0;
            mFerrCount = '0;
            return;
        end
        pop    = !mWordValid && (mFifo.size() > 0) && !flush;
        room   = (mFifo.size() < DEPTH) || pop;
        ferrEv = rxValid && rxFerr;
        pushEv = rxValid && !rxFerr && !flush && room;
        dropEv = rxValid && !rxFerr && !flush && !room;
        if (flush) begin
            mFifo.delete();
            mColl.delete();
            mWordValid = 1'b0;
        end else begin
            if (mWordValid && wordBus.word_ready) mWordValid = 1'b0;
            if (pop) begin
                mColl.push_back(mFifo.pop_front());
                if (mColl.size() == 4) begin
                    mWordOut   = {mColl[0], mColl[1], mColl[2], mColl[3]};
                    mWordValid = 1'b1;
                    mColl.delete();
                end
            end
            if (pushEv) mFifo.push_back(rxData);
        end
        if (ferrEv) begin
            if (clearErr)                 mFerrCount = 8'd1;
            else if (mFerrCount != 8'd255) mFerrCount = mFerrCount + 8'd1;
        end else if (clearErr) begin
            mFerrCount = 8'd0;
        end
        if (dropEv)        mOverflow = 1'b1;
        else if (clearErr) mOverflow = 1'b0;
    endtask

    // One clock: drive the inputs, note any handshake, then clock, update
    // the model and compare every output against it
    task automatic applyStimulus(input logic rv, input logic [7:0] d, input logic fe,
                                 input logic fl, input logic ce, input logic rdy);
        rxValid  = rv;
        rxData   = d;
        rxFerr   = fe;
        flush    = fl;
        clearErr = ce;
        wordBus.word_ready = rdy;
        if (rstn && !fl && wordBus.word_valid === 1'b1 && rdy)
            accepted.push_back(wordBus.word_out);
        @(posedge clk);
        #1;
        cycle++;
        if (wordBus.word_valid === 1'b1) begin
            wvHighCount++;
            if (firstWvCycle < 0) firstWvCycle = cycle;
        end
        modelStep();
        checkOutput("model word_valid", {31'd0, wordBus.word_valid}, {31'd0, mWordValid});
        checkOutput("model word_out",   wordBus.word_out, mWordOut);
        checkOutput("model fifo_level", {27'd0, fifoLevel}, mFifo.size());
        checkOutput("model overflow",   {31'd0, overflow}, {31'd0, mOverflow});
        checkOutput("model ferr_count", {24'd0, ferrCount}, {24'd0, mFerrCount});
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic sendByte(input logic [7:0] d, input logic fe, input logic rdy);
        applyStimulus(1'b1, d, fe, 1'b0, 1'b0, rdy);
    endtask

    task automatic doReset();
        rstn = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        accepted.delete();
    endtask

    // Compares the handed-over words with the expected list, then clears both
    task automatic checkWords(input string name);
        logic [31:0] act;
        checkOutput({name, " word count"}, accepted.size(), expWords.size());
        for (int i = 0; i < expWords.size(); i++) begin
            act = (i < accepted.size()) ? accepted[i] : 32'hxxxxxxxx;
            checkOutput($sformatf("%s word %0d", name, i), act, expWords[i]);
        end
        accepted.delete();
        expWords.delete();
    endtask

    initial begin
        logic [7:0] goodBytes[4];
        int strobeCycle;
        int phase;
        logic rv, fe, fl, ce, rdy;

        // Directed vectors, starting right after reset. Each row holds the
        // inputs and the outputs expected after that edge.
        vecs[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1, 1'b0, 0};
        vecs[1]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1, 1'b0, 0};
        vecs[2]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1, 1'b0, 0};
        vecs[3]  = '{1'b1, 8'hD4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1, 1'b0, 0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1B2C3D4, 0, 1'b0, 0};
        vecs[5]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1B2C3D4, 0, 1'b0, 1};
        vecs[6]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1B2C3D4, 1, 1'b0, 1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA1B2C3D4, 1, 1'b0, 1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA1B2C3D4, 0, 1'b0, 1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA1B2C3D4, 0, 1'b0, 0};
        vecs[10] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA1B2C3D4, 0, 1'b0, 1};
        vecs[11] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA1B2C3D4, 0, 1'b0, 1};
        vecs[12] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA1B2C3D4, 0, 1'b0, 1};
        vecs[13] = '{1'b1, 8'h88, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA1B2C3D4, 0, 1'b0, 2};

        rstn = 1'b0; rxValid = 1'b0; rxData = 8'h00; rxFerr = 1'b0;
        flush = 1'b0; clearErr = 1'b0; wordBus.word_ready = 1'b0;
        cycle = 0; wvHighCount = 0; firstWvCycle = -1;

        doReset();
        checkOutput("reset word_valid", {31'd0, wordBus.word_valid}, 32'd0);
        checkOutput("reset word_out",   wordBus.word_out, 32'd0);
        checkOutput("reset fifo_level", {27'd0, fifoLevel}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rv, vecs[i].d, vecs[i].fe, vecs[i].fl, vecs[i].ce, vecs[i].rdy);
            checkOutput($sformatf("vec%0d word_valid", i), {31'd0, wordBus.word_valid}, {31'd0, vecs[i].expWv});
            checkOutput($sformatf("vec%0d word_out", i),   wordBus.word_out, vecs[i].expWo);
            checkOutput($sformatf("vec%0d fifo_level", i), {27'd0, fifoLevel}, vecs[i].expLvl);
            checkOutput($sformatf("vec%0d overflow", i),   {31'd0, overflow}, {31'd0, vecs[i].expOv});
            checkOutput($sformatf("vec%0d ferr_count", i), {24'd0, ferrCount}, vecs[i].expFc);
        end

        // Good stream with spaced strobes. The word appears one sampled cycle
        // after the edge that wrote the fourth byte, and lasts for one cycle.
        $display("[TB] good stream");
        doReset();
        goodBytes = '{8'h12, 8'h34, 8'h56, 8'h78};
        strobeCycle = 0;
        for (int k = 0; k < 4; k++) begin
            sendByte(goodBytes[k], 1'b0, 1'b1);
            if (k == 3) begin
                strobeCycle  = cycle;
                wvHighCount  = 0;
                firstWvCycle = -1;
            end
            idle(9, 1'b1);
        end
        checkOutput("stream latency", firstWvCycle - strobeCycle, 32'd1);
        checkOutput("stream valid cycles", wvHighCount, 32'd1);
        checkOutput("stream level", {27'd0, fifoLevel}, 32'd0);
        expWords = {32'h12345678};
        checkWords("stream");

        // Back-pressure: 21 bytes while nothing is accepted
        $display("[TB] back-pressure");
        doReset();
        for (int k = 0; k < 21; k++) sendByte(8'(k), 1'b0, 1'b0);
        idle(3, 1'b0);
        checkOutput("bp word_valid", {31'd0, wordBus.word_valid}, 32'd1);
        checkOutput("bp word_out",   wordBus.word_out, 32'h00010203);
        checkOutput("bp level",      {27'd0, fifoLevel}, 32'd16);
        checkOutput("bp overflow",   {31'd0, overflow}, 32'd1);
        idle(40, 1'b1);
        checkOutput("bp overflow sticky", {31'd0, overflow}, 32'd1);
        checkOutput("bp level drained",   {27'd0, fifoLevel}, 32'd0);
        expWords = {32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 32'h10111213};
        checkWords("bp");

        // Framing-error byte dropped out of the middle of a word
        $display("[TB] framing error");
        doReset();
        sendByte(8'h11, 1'b0, 1'b1);
        sendByte(8'h22, 1'b1, 1'b1);
        sendByte(8'h33, 1'b0, 1'b1);
        sendByte(8'h44, 1'b0, 1'b1);
        sendByte(8'h55, 1'b0, 1'b1);
        idle(10, 1'b1);
        checkOutput("ferr count", {24'd0, ferrCount}, 32'd1);
        expWords = {32'h11334455};
        checkWords("ferr");

        // Flush abandons a half-collected word
        $display("[TB] flush mid-word");
        doReset();
        sendByte(8'hAA, 1'b0, 1'b1);
        sendByte(8'hBB, 1'b0, 1'b1);
        idle(3, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) sendByte(8'(k), 1'b0, 1'b1);
        idle(10, 1'b1);
        expWords = {32'h01020304};
        checkWords("flush");

        // Saturation and clear priority
        $display("[TB] saturation");
        doReset();
        for (int k = 0; k < 300; k++) sendByte(8'h5A, 1'b1, 1'b1);
        checkOutput("sat count", {24'd0, ferrCount}, 32'd255);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("clear count", {24'd0, ferrCount}, 32'd0);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("clear vs ferr", {24'd0, ferrCount}, 32'd1);

        // Reset while a word is held and five bytes are buffered
        $display("[TB] reset mid-operation");
        doReset();
        for (int k = 0; k < 9; k++) sendByte(8'h20 + 8'(k), 1'b0, 1'b0);
        idle(2, 1'b0);
        checkOutput("pre-reset valid", {31'd0, wordBus.word_valid}, 32'd1);
        checkOutput("pre-reset level", {27'd0, fifoLevel}, 32'd5);
        doReset();
        checkOutput("post-reset valid", {31'd0, wordBus.word_valid}, 32'd0);
        checkOutput("post-reset word",  wordBus.word_out, 32'd0);
        checkOutput("post-reset level", {27'd0, fifoLevel}, 32'd0);
        checkOutput("post-reset ovf",   {31'd0, overflow}, 32'd0);
        checkOutput("post-reset ferr",  {24'd0, ferrCount}, 32'd0);
        for (int k = 1; k <= 4; k++) sendByte(8'h30 + 8'(k), 1'b0, 1'b1);
        idle(10, 1'b1);
        expWords = {32'h31323334};
        checkWords("after reset");

        // Randomized run. Phases alternate between heavy traffic with a slow
        // consumer and light traffic with a fast consumer, so that both the
        // full-FIFO and the empty-FIFO paths are exercised.
        $display("[TB] random");
        doReset();
        for (int n = 0; n < 3000; n++) begin
            phase = (n / 250) % 2;
            rv  = (phase == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 2) == 0);
            rdy = (phase == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            fe  = ($urandom_range(0, 15) == 0);
            fl  = ($urandom_range(0, 199) == 0);
            ce  = ($urandom_range(0, 99) == 0);
            rstn = ($urandom_range(0, 999) != 0);
            applyStimulus(rv, 8'($urandom), fe, fl, ce, rdy);
            rstn = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
